sprite_line_scheduler: RTL and testbench
========================================

# sprite_line_scheduler

Per-line sprite evaluation and render sequencer for the sprite pipeline. On each line-start pulse it scans the whole sprite attribute table, one entry per cycle. It collects, in ascending sprite-number order, up to MAXS sprites whose 16-row pattern covers the target line, then issues them one by one to the line renderer over a valid/ready command channel. It sits between the sprite attribute RAM (its combinational read port) and the line renderer / line buffer writer.

## Interface
Parameters:
- NB, 7, sprite index width; table holds N = 1<<NB entries
- SH, 16, sprite height in rows (power of two, ≤16)
- MAXS, 16, max sprites issued per line; list depth

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- line_start  in  1  one-cycle pulse: begin evaluation for target_y
- target_y  in  8  line to evaluate, sampled on line_start
- rd_idx  out  NB  sprite RAM read address
- rd_x, rd_y  in  8 each  sprite position at rd_idx, same-cycle (combinational) read
- cmd_valid  out  1  command available
- cmd_ready  in  1  renderer accepts command
- cmd_spno  out  NB  sprite number
- cmd_x  out  8  sprite x
- cmd_row  out  4  pattern row = target_y − sprite y
- busy  out  1  high in SCAN/ISSUE/DONE
- done  out  1  one-cycle pulse, line fully issued
- overflow  out  1  more than MAXS hits on this line
- count  out  $clog2(MAXS+1)  number of sprites collected

## Operation
- FSM states: IDLE, SCAN, ISSUE, DONE.
- IDLE: line_start → latch target_y, clear count/overflow/list pointers, rd_idx=0, go SCAN.
- SCAN, each cycle: row = (target_y − rd_y) mod 256, 8-bit wrap.
  - hit = row < SH.
  - If hit and count < MAXS: store {rd_idx, rd_x, row[3:0]}, count++.
  - If hit and count == MAXS: overflow=1, entry dropped.
  - rd_idx++ each cycle.
  - After processing rd_idx = N−1: go ISSUE if count > 0, else DONE.
- ISSUE: cmd_valid=1 with entry at the read pointer.
  - On cmd_valid && cmd_ready: pointer++.
  - Handshake on the last entry (pointer == count−1) → DONE.
- DONE: done=1 for one cycle, then IDLE.
- line_start in any non-IDLE state: abort and restart as from IDLE. The list is cleared, cmd_valid drops the next cycle, and no done is pulsed for the aborted line.
- cmd_* stable while cmd_valid && !cmd_ready. cmd_valid never deasserts without a handshake, except on abort or reset.
- overflow and count hold their values until the next line_start.
- rd_idx holds its last value outside SCAN.

## Timing
- Reset (rst=0, asynchronous): state IDLE; rd_idx=0, cmd_valid=0, cmd_spno=0, cmd_x=0, cmd_row=0, busy=0, done=0, overflow=0, count=0.
- line_start at edge t:
  - SCAN covers cycles t+1 … t+N, with rd_idx = k at cycle t+1+k.
  - busy=1 from t+1.
- Hits present: first cmd_valid at t+N+1.
  - With cmd_ready held high, one command per cycle; last command at t+N+count.
  - done at t+N+count+1; busy=0 and IDLE from t+N+count+2.
- Zero hits: done at t+N+1, no cmd_valid.
- Hit/store decided combinationally from rd_y in the same cycle. The list write is registered, so there is no extra scan latency.

## Test plan
- Single hit: sprite 5 at (x=40, y=100), all others y=200, target_y=107 → one command spno=5, x=40, row=7 at t+N+1; done at t+N+2; count=1, overflow=0.
- Row boundaries: sprite 0 at y=100.
  - target 115 → row=15, issued.
  - target 116 → none.
  - target 99 → none (wrap gives row 255).
  - Sprite at y=250, target 3 → row=9, issued.
- Overflow: sprites 0..19 at y=0, rest y=200, target_y=3 → 16 commands spno 0..15, row=3; count=16; overflow=1; spno 16..19 never issued.
- Backpressure: 3 hits, cmd_ready pattern 0,1,0,0,1,1 → cmd_* stable while stalled; all 3 delivered in order exactly once; done 1 cycle after the final handshake.
- Zero hits: target_y with no covering sprite → no cmd_valid; done pulses once at t+N+1; count=0.
- Restart and reset:
  - line_start mid-ISSUE (new target_y) → cmd_valid low the next cycle, a fresh scan from rd_idx=0, only the new line's commands, and one done.
  - rst asserted mid-SCAN → all outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Sprite line scheduler: on each line_start, walks the whole sprite attribute
// table one entry per cycle, keeps the first MAXS sprites (lowest number first)
// whose pattern rows cover target_y, then hands them to the line renderer one
// at a time over a valid/ready command channel.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   line_start/target_y begin (or restart) evaluation of target_y
//   rd_idx, rd_x, rd_y  sprite attribute RAM address / same-cycle read data
//   cmd_valid/ready     command handshake to the renderer
//   cmd_spno/x/row      command payload: sprite number, x, pattern row
//   busy, done          activity flag, one-cycle end-of-line pulse
//   overflow, count     more than MAXS hits seen / number of sprites kept
module sprite_line_scheduler #(
  parameter int unsigned NB   = 7,
  parameter int unsigned SH   = 16,
  parameter int unsigned MAXS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_start,
  input  logic [7:0]                target_y,
  output logic [NB-1:0]             rd_idx,
  input  logic [7:0]                rd_x,
  input  logic [7:0]                rd_y,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [NB-1:0]             cmd_spno,
  output logic [7:0]                cmd_x,
  output logic [3:0]                cmd_row,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [$clog2(MAXS+1)-1:0] count
);

  localparam int unsigned CW = $clog2(MAXS + 1);
  localparam int unsigned PW = (MAXS > 1) ? $clog2(MAXS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      target_q, target_d;
  logic [NB-1:0]   rd_idx_q, rd_idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [NB-1:0]   cmd_spno_q, cmd_spno_d;
  logic [7:0]      cmd_x_q, cmd_x_d;
  logic [3:0]      cmd_row_q, cmd_row_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Collected sprite list; only entries below count_q are ever read.
  logic [NB-1:0]   list_spno_q [MAXS];
  logic [7:0]      list_x_q    [MAXS];
  logic [3:0]      list_row_q  [MAXS];

  logic [7:0]      row_c;
  logic            hit_c;
  logic            store_c;
  logic [PW-1:0]   nxt_ptr_c;

  // Row within the sprite pattern; wraps so sprites straddling y=255 work.
  assign row_c     = target_q - rd_y;
  assign hit_c     = (state_q == S_SCAN) && (row_c < 8'(SH));
  assign store_c   = hit_c && (count_q < CW'(MAXS));
  assign nxt_ptr_c = ptr_q + PW'(1);

  // List write: the entry is captured at the end of its scan cycle.
  always_ff @(posedge clk) begin
    if (store_c) begin
      list_spno_q[PW'(count_q)] <= rd_idx_q;
      list_x_q[PW'(count_q)]    <= rd_x;
      list_row_q[PW'(count_q)]  <= row_c[3:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    rd_idx_d    = rd_idx_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    ptr_d       = ptr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_spno_d  = cmd_spno_q;
    cmd_x_d     = cmd_x_q;
    cmd_row_d   = cmd_row_q;

    if (line_start) begin
      // Start or abort-and-restart; an aborted line never pulses done.
      state_d     = S_SCAN;
      target_d    = target_y;
      rd_idx_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      ptr_d       = '0;
      cmd_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_SCAN: begin
          if (store_c) begin
            count_d = count_q + CW'(1);
          end else if (hit_c) begin
            overflow_d = 1'b1;
          end
          if (&rd_idx_q) begin
            if (count_d != '0) begin
              state_d     = S_ISSUE;
              cmd_valid_d = 1'b1;
              // Entry 0 may be the one being written this very cycle.
              if (store_c && (count_q == '0)) begin
                cmd_spno_d = rd_idx_q;
                cmd_x_d    = rd_x;
                cmd_row_d  = row_c[3:0];
              end else begin
                cmd_spno_d = list_spno_q[0];
                cmd_x_d    = list_x_q[0];
                cmd_row_d  = list_row_q[0];
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            rd_idx_d = rd_idx_q + NB'(1);
          end
        end
        S_ISSUE: begin
          if (cmd_valid_q && cmd_ready) begin
            if (CW'(ptr_q) == (count_q - CW'(1))) begin
              state_d     = S_DONE;
              cmd_valid_d = 1'b0;
            end else begin
              ptr_d      = nxt_ptr_c;
              cmd_spno_d = list_spno_q[nxt_ptr_c];
              cmd_x_d    = list_x_q[nxt_ptr_c];
              cmd_row_d  = list_row_q[nxt_ptr_c];
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      ptr_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_spno_q  <= '0;
      cmd_x_q     <= '0;
      cmd_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      rd_idx_q    <= rd_idx_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_spno_q  <= cmd_spno_d;
      cmd_x_q     <= cmd_x_d;
      cmd_row_q   <= cmd_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_idx    = rd_idx_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_spno  = cmd_spno_q;
  assign cmd_x     = cmd_x_q;
  assign cmd_row   = cmd_row_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: a sprite table model drives
// the combinational read port, and a list-based reference model predicts the
// command stream, count and overflow for each line.
module tb_sprite_line_scheduler;

  localparam int unsigned NB   = 7;
  localparam int unsigned N    = 1 << NB;
  localparam int unsigned SH   = 16;
  localparam int unsigned MAXS = 16;
  localparam int unsigned CW   = $clog2(MAXS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          line_start;
  logic [7:0]    target_y;
  logic [NB-1:0] rd_idx;
  logic [7:0]    rd_x, rd_y;
  logic          cmd_valid, cmd_ready;
  logic [NB-1:0] cmd_spno;
  logic [7:0]    cmd_x;
  logic [3:0]    cmd_row;
  logic          busy, done, overflow;
  logic [CW-1:0] count;

  logic [7:0] spr_x [N];
  logic [7:0] spr_y [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_x = spr_x[rd_idx];
  assign rd_y = spr_y[rd_idx];

  sprite_line_scheduler #(.NB(NB), .SH(SH), .MAXS(MAXS)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .target_y(target_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_spno(cmd_spno), .cmd_x(cmd_x), .cmd_row(cmd_row),
    .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  // Reference model: commands packed as spno<<12 | x<<4 | row.
  int exp_q[$];
  int exp_count;
  bit exp_ovf;

  function automatic void model(input logic [7:0] ty);
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      int row = (int'(ty) - int'(spr_y[i]) + 256) % 256;
      if (row < int'(SH)) begin
        if (exp_q.size() < int'(MAXS)) exp_q.push_back((i << 12) | (int'(spr_x[i]) << 4) | row);
        else exp_ovf = 1'b1;
      end
    end
    exp_count = exp_q.size();
  endfunction

  function automatic void set_bg();
    for (int i = 0; i < int'(N); i++) begin
      spr_y[i] = 8'd200;
      spr_x[i] = 8'($urandom);
    end
  endfunction

  // Observations gathered by collect(); cycle numbers are relative to the
  // edge that sampled line_start.
  int ready_mode;
  int ready_pat[$];
  int got_q[$];
  int hs_cyc[$];
  int first_valid, done_cyc, done_cnt, stable_err, scan_err, busy_err;
  bit timed_out;
  logic busy_after, done_after, ovf_after;
  logic [CW-1:0] cnt_after;

  task automatic pulse_line(input logic [7:0] ty);
    @(negedge clk);
    line_start = 1'b1;
    target_y   = ty;
  endtask

  task automatic collect(input int budget);
    int vcnt = 0;
    int prev = 0;
    int cur;
    bit stalled = 1'b0;
    got_q.delete();
    hs_cyc.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0;
    stable_err = 0; scan_err = 0; busy_err = 0; timed_out = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      line_start = 1'b0;
      if (cyc <= int'(N) && rd_idx !== NB'(cyc - 1)) scan_err++;
      if (done_cyc >= 0) begin
        busy_after = busy; done_after = done; cnt_after = count; ovf_after = overflow;
        timed_out = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      cur = int'({cmd_spno, cmd_x, cmd_row});
      if (cmd_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled && cur != prev) stable_err++;
        case (ready_mode)
          0:       cmd_ready = 1'b1;
          1:       cmd_ready = (vcnt < ready_pat.size()) ? 1'(ready_pat[vcnt]) : 1'b1;
          default: cmd_ready = 1'($urandom_range(0, 1));
        endcase
        vcnt++;
        if (cmd_ready) begin
          got_q.push_back(cur);
          hs_cyc.push_back(cyc);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev    = cur;
        end
      end else begin
        if (stalled) stable_err++;
        stalled   = 1'b0;
        cmd_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; line_start = 1'b0; cmd_ready = 1'b0; target_y = 8'd0;
    set_bg();
    repeat (3) @(negedge clk);
    checks++; if (rd_idx !== '0) begin errors++; $display("FAIL reset_rd_idx: got %0d expected 0", rd_idx); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b expected 0", cmd_valid); end
    checks++; if ({cmd_spno, cmd_x, cmd_row} !== '0) begin errors++; $display("FAIL reset_cmd_payload: got %0h expected 0", {cmd_spno, cmd_x, cmd_row}); end
    checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, overflow}); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_hit();
    set_bg();
    spr_x[5] = 8'd40; spr_y[5] = 8'd100;
    ready_mode = 0;
    pulse_line(8'd107);
    collect(400);
    checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: got no done within budget expected done"); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_ncmd: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] != ((5 << 12) | (40 << 4) | 7)) begin errors++; $display("FAIL single_cmd: got %0h expected %0h", got_q[0], (5 << 12) | (40 << 4) | 7); end
    end
    checks++; if (first_valid != int'(N) + 1) begin errors++; $display("FAIL single_first_valid: got %0d expected %0d", first_valid, N + 1); end
    checks++; if (done_cyc != int'(N) + 2) begin errors++; $display("FAIL single_done_cyc: got %0d expected %0d", done_cyc, N + 2); end
    checks++; if (cnt_after !== CW'(1) || ovf_after !== 1'b0) begin errors++; $display("FAIL single_count_ovf: got %0d/%0b expected 1/0", cnt_after, ovf_after); end
    checks++; if (scan_err != 0 || busy_err != 0) begin errors++; $display("FAIL single_scan_busy: got %0d/%0d errors expected 0/0", scan_err, busy_err); end
    checks++; if (busy_after !== 1'b0 || done_after !== 1'b0) begin errors++; $display("FAIL single_after_done: got busy=%0b done=%0b expected 0/0", busy_after, done_after); end
  endtask

  task automatic test_row_boundaries();
    int ys[4]   = '{100, 100, 100, 250};
    int tys[4]  = '{115, 116, 99, 3};
    int rows[4] = '{15, -1, -1, 9};
    int e;
    ready_mode = 0;
    for (int k = 0; k < 4; k++) begin
      set_bg();
      spr_y[0] = 8'(ys[k]);
      pulse_line(8'(tys[k]));
      collect(400);
      e = (int'(spr_x[0]) << 4) | rows[k];
      if (rows[k] < 0) begin
        checks++; if (got_q.size() != 0 || done_cyc != int'(N) + 1) begin errors++; $display("FAIL bound_none_%0d: got %0d cmds done@%0d expected 0 cmds done@%0d", k, got_q.size(), done_cyc, N + 1); end
      end else begin
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bound_ncmd_%0d: got %0d expected 1", k, got_q.size()); end
        else begin
          checks++; if (got_q[0] != e) begin errors++; $display("FAIL bound_cmd_%0d: got %0h expected %0h", k, got_q[0], e); end
        end
      end
    end
  endtask

  task automatic test_overflow();
    set_bg();
    for (int i = 0; i < 20; i++) spr_y[i] = 8'd0;
    ready_mode = 0;
    pulse_line(8'd3);
    collect(400);
    checks++; if (got_q.size() != int'(MAXS)) begin errors++; $display("FAIL ovf_ncmd: got %0d expected %0d", got_q.size(), MAXS); end
    for (int k = 0; k < got_q.size() && k < int'(MAXS); k++) begin
      checks++;
      if (got_q[k] != ((k << 12) | (int'(spr_x[k]) << 4) | 3)) begin
        errors++; $display("FAIL ovf_cmd_%0d: got %0h expected %0h", k, got_q[k], (k << 12) | (int'(spr_x[k]) << 4) | 3);
      end
    end
    checks++; if (cnt_after !== CW'(MAXS) || ovf_after !== 1'b1) begin errors++; $display("FAIL ovf_count_flag: got %0d/%0b expected %0d/1", cnt_after, ovf_after, MAXS); end
    checks++; if (done_cyc != int'(N + MAXS) + 1) begin errors++; $display("FAIL ovf_done_cyc: got %0d expected %0d", done_cyc, N + MAXS + 1); end
  endtask

  task automatic test_backpressure();
    set_bg();
    spr_y[10] = 8'd60; spr_y[50] = 8'd58; spr_y[90] = 8'd50;
    model(8'd62);
    ready_mode = 1;
    ready_pat  = {0, 1, 0, 0, 1, 1};
    pulse_line(8'd62);
    collect(400);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_ncmd: got %0d expected 3", got_q.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL bp_cmd_%0d: got %0h expected %0h", k, got_q[k], exp_q[k]); end
      end
      checks++;
      if (hs_cyc[0] != int'(N) + 2 || hs_cyc[1] != int'(N) + 5 || hs_cyc[2] != int'(N) + 6) begin
        errors++; $display("FAIL bp_hs_cycles: got %0d,%0d,%0d expected %0d,%0d,%0d", hs_cyc[0], hs_cyc[1], hs_cyc[2], N + 2, N + 5, N + 6);
      end
    end
    checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stable_err); end
    checks++; if (done_cyc != int'(N) + 7 || done_cnt != 1) begin errors++; $display("FAIL bp_done: got cyc %0d cnt %0d expected cyc %0d cnt 1", done_cyc, done_cnt, N + 7); end
  endtask

  task automatic test_zero_hits();
    set_bg();
    ready_mode = 0;
    pulse_line(8'd50);
    collect(400);
    checks++; if (first_valid != -1) begin errors++; $display("FAIL zero_valid: got valid at %0d expected never", first_valid); end
    checks++; if (done_cyc != int'(N) + 1 || done_cnt != 1 || done_after !== 1'b0) begin errors++; $display("FAIL zero_done: got cyc %0d cnt %0d expected cyc %0d cnt 1", done_cyc, done_cnt, N + 1); end
    checks++; if (cnt_after !== '0 || ovf_after !== 1'b0) begin errors++; $display("FAIL zero_count: got %0d/%0b expected 0/0", cnt_after, ovf_after); end
  endtask

  task automatic test_random();
    logic [7:0] ty;
    int exp_done;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < int'(N); i++) begin
        spr_x[i] = 8'($urandom);
        spr_y[i] = (it % 2 == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      end
      ty = (it % 2 == 1) ? 8'($urandom_range(10, 40)) : 8'($urandom);
      model(ty);
      ready_mode = 2;
      pulse_line(ty);
      collect(2000);
      exp_done = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size() - 1] + 1 : int'(N) + 1;
      checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout_%0d: got no done expected done", it); end
      checks++; if (got_q.size() != exp_count) begin errors++; $display("FAIL rand_ncmd_%0d: got %0d expected %0d", it, got_q.size(), exp_count); end
      for (int k = 0; k < exp_count && k < got_q.size(); k++) begin
        checks++; if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL rand_cmd_%0d_%0d: got %0h expected %0h", it, k, got_q[k], exp_q[k]); end
      end
      checks++; if (cnt_after !== CW'(exp_count) || ovf_after !== exp_ovf) begin errors++; $display("FAIL rand_count_%0d: got %0d/%0b expected %0d/%0b", it, cnt_after, ovf_after, exp_count, exp_ovf); end
      checks++; if (done_cyc != exp_done || done_cnt != 1 || done_after !== 1'b0) begin errors++; $display("FAIL rand_done_%0d: got cyc %0d cnt %0d expected cyc %0d cnt 1", it, done_cyc, done_cnt, exp_done); end
      checks++; if (stable_err != 0 || scan_err != 0 || busy_err != 0) begin errors++; $display("FAIL rand_proto_%0d: got %0d/%0d/%0d errors expected 0/0/0", it, stable_err, scan_err, busy_err); end
    end
  endtask

  task automatic test_restart();
    set_bg();
    spr_y[1] = 8'd100; spr_y[2] = 8'd100; spr_y[3] = 8'd100;
    spr_y[7] = 8'd30;  spr_y[8] = 8'd30;
    cmd_ready = 1'b0;
    pulse_line(8'd105);
    repeat (N + 3) begin
      @(negedge clk);
      line_start = 1'b0;
      cmd_ready  = 1'b0;
    end
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL restart_in_issue: got cmd_valid %0b expected 1", cmd_valid); end
    model(8'd40);
    ready_mode = 0;
    pulse_line(8'd40);
    collect(400);
    checks++; if (first_valid != int'(N) + 1) begin errors++; $display("FAIL restart_valid_drop: got first valid %0d expected %0d", first_valid, N + 1); end
    checks++; if (scan_err != 0) begin errors++; $display("FAIL restart_scan: got %0d rd_idx errors expected 0", scan_err); end
    checks++; if (got_q.size() != exp_count) begin errors++; $display("FAIL restart_ncmd: got %0d expected %0d", got_q.size(), exp_count); end
    else begin
      for (int k = 0; k < exp_count; k++) begin
        checks++; if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL restart_cmd_%0d: got %0h expected %0h", k, got_q[k], exp_q[k]); end
      end
    end
    checks++; if (done_cnt != 1 || done_cyc != int'(N) + 3) begin errors++; $display("FAIL restart_done: got cnt %0d cyc %0d expected cnt 1 cyc %0d", done_cnt, done_cyc, N + 3); end
  endtask

  task automatic test_async_reset();
    set_bg();
    spr_y[0] = 8'd0; spr_y[1] = 8'd0; spr_y[2] = 8'd0;
    ready_mode = 0;
    pulse_line(8'd5);
    repeat (10) begin
      @(negedge clk);
      line_start = 1'b0;
    end
    checks++; if (count !== CW'(3) || busy !== 1'b1) begin errors++; $display("FAIL areset_pre: got count %0d busy %0b expected 3/1", count, busy); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({rd_idx, cmd_valid, cmd_spno, cmd_x, cmd_row, done, overflow} !== '0) begin errors++; $display("FAIL areset_outputs: got %0h expected 0", {rd_idx, cmd_valid, cmd_spno, cmd_x, cmd_row, done, overflow}); end
    checks++; if (busy !== 1'b0 || count !== '0) begin errors++; $display("FAIL areset_busy_count: got %0b/%0d expected 0/0", busy, count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model(8'd5);
    pulse_line(8'd5);
    collect(400);
    checks++; if (got_q.size() != exp_count || cnt_after !== CW'(exp_count)) begin errors++; $display("FAIL areset_recover: got %0d cmds count %0d expected %0d", got_q.size(), cnt_after, exp_count); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_row_boundaries();
    test_overflow();
    test_backpressure();
    test_zero_hits();
    test_random();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
